// File: rtl/delay_gen_pkg.sv
// Shared types and constants for the GVIZI delay-signal channel array.
// The optional overrun event counter is controlled by DELAY_OVR_CNT_EN.
package delay_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } ch_state_e;

    typedef enum logic {
        MODE_GZI = 1'b0,
        MODE_GVI = 1'b1
    } mode_e;

    localparam int OVR_CNT_W = 8;

    // Saturating increment used by the per-channel overrun event counter.
    function automatic logic [OVR_CNT_W-1:0] ovr_sat_inc(input logic [OVR_CNT_W-1:0] v);
        return (v == {OVR_CNT_W{1'b1}}) ? v : v + OVR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/delay_ch_fsm.sv
// One delay/pulse channel: config latches, IDLE/DELAY/PULSE FSM, counter and feedback synchroniser.
// With DELAY_OVR_CNT_EN defined, a saturating overrun event counter is added (o_ovr_cnt).
module delay_ch_fsm
    import delay_gen_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start_p,
    input  logic                 i_ch_en,
    input  logic                 i_mode,
    input  logic [CNT_W-1:0]     i_delay,
    input  logic [CNT_W-1:0]     i_width,
    input  logic                 i_abort,
    input  logic                 i_gzi_fb,
    output logic                 o_out,
    output logic                 o_overrun,
`ifdef DELAY_OVR_CNT_EN
    output logic [OVR_CNT_W-1:0] o_ovr_cnt,
`endif
    output ch_state_e            o_state
);

    ch_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   delay_q, delay_d;
    logic [CNT_W-1:0]   width_q, width_d;
    mode_e              mode_q, mode_d;
    logic               out_q, out_d;
    logic               ovr_q;
    logic               ovr_hit;
    logic [SYNC_N-1:0]  fb_sync_q;
    logic               fb_low;
    logic [CNT_W-1:0]   gvi_width;
    logic               pulse_done;

    assign fb_low    = ~fb_sync_q[SYNC_N-1];
    assign gvi_width = (width_q == '0) ? CNT_W'(1) : width_q;

    // GZI ends on synced feedback low or on the optional timeout (width 0 = wait forever).
    always_comb begin
        pulse_done = 1'b0;
        if (mode_q == MODE_GVI) begin
            pulse_done = (cnt_q == gvi_width - CNT_W'(1));
        end else begin
            pulse_done = fb_low || ((width_q != '0) && (cnt_q == width_q - CNT_W'(1)));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        width_d = width_q;
        mode_d  = mode_q;
        out_d   = out_q;
        ovr_hit = 1'b0;
        if (i_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start_p && i_ch_en) begin
                        delay_d = i_delay;
                        width_d = i_width;
                        mode_d  = mode_e'(i_mode);
                        cnt_d   = '0;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    ovr_hit = i_start_p;
                    if (cnt_q == delay_q) begin
                        cnt_d   = '0;
                        out_d   = 1'b1;
                        state_d = PULSE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PULSE: begin
                    ovr_hit = i_start_p;
                    if (pulse_done) begin
                        cnt_d   = '0;
                        out_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    out_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            delay_q   <= '0;
            width_q   <= '0;
            mode_q    <= MODE_GZI;
            out_q     <= 1'b0;
            ovr_q     <= 1'b0;
            fb_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            delay_q   <= delay_d;
            width_q   <= width_d;
            mode_q    <= mode_d;
            out_q     <= out_d;
            ovr_q     <= ovr_q | ovr_hit;
            fb_sync_q <= {fb_sync_q[SYNC_N-2:0], i_gzi_fb};
        end
    end

`ifdef DELAY_OVR_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovr_cnt_q <= '0;
        end else if (ovr_hit) begin
            ovr_cnt_q <= ovr_sat_inc(ovr_cnt_q);
        end
    end

    assign o_ovr_cnt = ovr_cnt_q;
`endif

    assign o_out     = out_q;
    assign o_overrun = ovr_q;
    assign o_state   = state_q;

endmodule

// File: rtl/delay_ch_array.sv
// N-channel programmable delay/pulse generator: shared start synchroniser and edge detector,
// per-channel delay_ch_fsm instances. DELAY_OVR_CNT_EN adds the o_ovr_cnt port.
module delay_ch_array
    import delay_gen_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [N_CH-1:0]             i_ch_en,
    input  logic [N_CH-1:0]             i_mode,
    input  logic [N_CH*CNT_W-1:0]       i_delay,
    input  logic [N_CH*CNT_W-1:0]       i_width,
    input  logic [N_CH-1:0]             i_abort,
    input  logic [N_CH-1:0]             i_gzi_fb,
    output logic [N_CH-1:0]             o_out,
    output logic [N_CH-1:0]             o_busy,
`ifdef DELAY_OVR_CNT_EN
    output logic [N_CH*OVR_CNT_W-1:0]   o_ovr_cnt,
`endif
    output logic [N_CH-1:0]             o_overrun
);

    logic [SYNC_N-1:0] start_sync_q;
    logic              start_s_q;
    logic              start_p;
    ch_state_e         ch_state [N_CH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_sync_q <= '0;
            start_s_q    <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_N-2:0], i_start};
            start_s_q    <= start_sync_q[SYNC_N-1];
        end
    end

    // One-clock launch strobe on the synchronised rising edge of the shared trigger.
    assign start_p = start_sync_q[SYNC_N-1] & ~start_s_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        delay_ch_fsm #(
            .CNT_W  (CNT_W),
            .SYNC_N (SYNC_N)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_start_p (start_p),
            .i_ch_en   (i_ch_en[k]),
            .i_mode    (i_mode[k]),
            .i_delay   (i_delay[k*CNT_W +: CNT_W]),
            .i_width   (i_width[k*CNT_W +: CNT_W]),
            .i_abort   (i_abort[k]),
            .i_gzi_fb  (i_gzi_fb[k]),
            .o_out     (o_out[k]),
            .o_overrun (o_overrun[k]),
`ifdef DELAY_OVR_CNT_EN
            .o_ovr_cnt (o_ovr_cnt[k*OVR_CNT_W +: OVR_CNT_W]),
`endif
            .o_state   (ch_state[k])
        );

        assign o_busy[k] = (ch_state[k] != IDLE);
    end

endmodule
